// File: rtl/cr16_datapath_sequencer_pkg.sv
// Shared types for the cr16 micro-sequencer: FSM states and the 32-bit micro-op layout.
package cr16_datapath_sequencer_pkg;

    localparam int UOP_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bit 31 down to bit 0: LAST, IMM_SEL, NO_WB, reserved, opcode, dest, src_a, imm/src_b.
    typedef struct packed {
        logic        last;
        logic        imm_sel;
        logic        no_wb;
        logic        rsvd;
        logic [3:0]  opcode;
        logic [3:0]  dest;
        logic [3:0]  src_a;
        logic [15:0] imm;
    } uop_t;

endpackage

// File: rtl/cr16_datapath_sequencer_if.sv
// Launch handshake, micro-op ROM port, datapath control/result bus and debug state of the sequencer.
interface cr16_datapath_sequencer_if
    import cr16_datapath_sequencer_pkg::*;
#(
    parameter int AW = 8
);
    logic              I_START;
    logic              I_CLEAR_REGS;
    logic              I_HOLD;
    logic [AW-1:0]     O_ROM_ADDR;
    logic [UOP_W-1:0]  I_ROM_DATA;
    logic              O_DP_NRESET;
    logic [15:0]       O_DP_REG_EN;
    logic [3:0]        O_DP_A_SEL;
    logic [3:0]        O_DP_B_SEL;
    logic [15:0]       O_DP_IMM;
    logic              O_DP_IMM_SEL;
    logic [3:0]        O_DP_OPCODE;
    logic [15:0]       I_DP_WRITE;
    logic [4:0]        I_DP_FLAGS;
    logic              O_BUSY;
    logic              O_DONE;
    logic              O_OVERRUN;
    logic [15:0]       O_RESULT;
    logic [4:0]        O_FLAGS;
    state_t            O_DBG_STATE;

    // Handshake: I_START is a level sampled only while O_BUSY=0; O_DONE is a
    // single-cycle pulse ending the program, and no new start is accepted until
    // O_BUSY has returned low.
    modport slave (
        input  I_START, I_CLEAR_REGS, I_HOLD, I_ROM_DATA, I_DP_WRITE, I_DP_FLAGS,
        output O_ROM_ADDR, O_DP_NRESET, O_DP_REG_EN, O_DP_A_SEL, O_DP_B_SEL,
               O_DP_IMM, O_DP_IMM_SEL, O_DP_OPCODE, O_BUSY, O_DONE, O_OVERRUN,
               O_RESULT, O_FLAGS, O_DBG_STATE
    );

    modport master (
        output I_START, I_CLEAR_REGS, I_HOLD, I_ROM_DATA, I_DP_WRITE, I_DP_FLAGS,
        input  O_ROM_ADDR, O_DP_NRESET, O_DP_REG_EN, O_DP_A_SEL, O_DP_B_SEL,
               O_DP_IMM, O_DP_IMM_SEL, O_DP_OPCODE, O_BUSY, O_DONE, O_OVERRUN,
               O_RESULT, O_FLAGS, O_DBG_STATE
    );

endinterface

// File: rtl/cr16_datapath_sequencer_uop_decode.sv
// Combinational micro-op decoder: turns the ROM word into datapath controls, gated by exec_en.
module cr16_datapath_sequencer_uop_decode
    import cr16_datapath_sequencer_pkg::*;
(
    input  logic [UOP_W-1:0] rom_data,
    input  logic             exec_en,
    output logic [15:0]      reg_en,
    output logic [3:0]       a_sel,
    output logic [3:0]       b_sel,
    output logic [15:0]      imm,
    output logic             imm_sel,
    output logic [3:0]       opcode,
    output logic             last,
    output logic             no_wb
);
    uop_t uop;
    logic unused_rsvd;

    assign uop         = uop_t'(rom_data);
    // The reserved bit carries no meaning; it is deliberately ignored.
    assign unused_rsvd = uop.rsvd;
    assign last        = uop.last;
    assign no_wb       = uop.no_wb;

    always_comb begin
        reg_en  = '0;
        a_sel   = '0;
        b_sel   = '0;
        imm     = '0;
        imm_sel = 1'b0;
        opcode  = '0;
        if (exec_en) begin
            a_sel   = uop.src_a;
            opcode  = uop.opcode;
            imm_sel = uop.imm_sel;
            if (uop.imm_sel) begin
                imm = uop.imm;
            end else begin
                b_sel = uop.imm[3:0];
            end
            if (!uop.no_wb) begin
                reg_en = 16'h0001 << uop.dest;
            end
        end
    end

endmodule

// File: rtl/cr16_datapath_sequencer.sv
// Fetch/execute micro-sequencer driving the cr16 datapath from an external synchronous micro-op ROM.
module cr16_datapath_sequencer
    import cr16_datapath_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
)
(
    input  logic                      I_CLK,
    input  logic                      I_NRESET,
    cr16_datapath_sequencer_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic                  overrun_q, overrun_nxt;
    logic [15:0]           result_q;
    logic [4:0]            flags_q;
    logic                  exec_en;
    logic                  uop_last;
    logic                  uop_no_wb;

    assign exec_en = (state == ST_EXEC);

    cr16_datapath_sequencer_uop_decode u_decode (
        .rom_data (bus.I_ROM_DATA),
        .exec_en  (exec_en),
        .reg_en   (bus.O_DP_REG_EN),
        .a_sel    (bus.O_DP_A_SEL),
        .b_sel    (bus.O_DP_B_SEL),
        .imm      (bus.O_DP_IMM),
        .imm_sel  (bus.O_DP_IMM_SEL),
        .opcode   (bus.O_DP_OPCODE),
        .last     (uop_last),
        .no_wb    (uop_no_wb)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state     <= ST_IDLE;
            pc        <= START_ADDR;
            overrun_q <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            overrun_q <= overrun_nxt;
            if (exec_en) begin
                flags_q <= bus.I_DP_FLAGS;
                if (!uop_no_wb) begin
                    result_q <= bus.I_DP_WRITE;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        overrun_nxt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.I_START) begin
                    pc_nxt    = START_ADDR;
                    state_nxt = bus.I_CLEAR_REGS ? ST_CLEAR : ST_FETCH;
                end
            end
            ST_CLEAR: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (!bus.I_HOLD) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (uop_last) begin
                    state_nxt = ST_DONE;
                end else if (pc == PC_MAX) begin
                    // Program ran off the end of the ROM: stop rather than wrap.
                    state_nxt   = ST_DONE;
                    overrun_nxt = 1'b1;
                end else begin
                    pc_nxt    = pc + 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.O_ROM_ADDR  = pc;
    assign bus.O_DP_NRESET = I_NRESET & (state != ST_CLEAR);
    assign bus.O_BUSY      = (state != ST_IDLE);
    assign bus.O_DONE      = (state == ST_DONE);
    assign bus.O_OVERRUN   = (state == ST_DONE) & overrun_q;
    assign bus.O_RESULT    = result_q;
    assign bus.O_FLAGS     = flags_q;
    assign bus.O_DBG_STATE = state;

endmodule

// File: tb/tb_cr16_datapath_sequencer.sv
// Bench for cr16_datapath_sequencer: behavioural ROM and datapath stub, DONE scoreboard, directed checks.
module tb_cr16_datapath_sequencer;
    import cr16_datapath_sequencer_pkg::*;

    localparam int EW = 33;  // {latency[15:0], overrun, result[15:0]}

    logic        clk;
    logic        nrst;
    int          cyc;
    int          start_cyc;
    int          n_done;
    int          n_tests;
    int          n_fail;
    logic [31:0] rom [256];
    logic [15:0] dp_regs [16];
    logic [15:0] alu_a, alu_b, alu_w;
    logic        alu_c;
    logic [EW-1:0] exp_q [$];

    cr16_datapath_sequencer_if #(.AW(8)) bus ();

    cr16_datapath_sequencer #(.ADDR_WIDTH(8), .START_ADDR(8'h00)) dut (
        .I_CLK    (clk),
        .I_NRESET (nrst),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ROM and datapath stub ----------------
    always @(posedge clk) bus.I_ROM_DATA <= rom[bus.O_ROM_ADDR];

    always_comb begin
        alu_a = dp_regs[bus.O_DP_A_SEL];
        alu_b = bus.O_DP_IMM_SEL ? bus.O_DP_IMM : dp_regs[bus.O_DP_B_SEL];
        {alu_c, alu_w} = {1'b0, alu_a} + {1'b0, alu_b};
        if (bus.O_DP_OPCODE != 4'h1) begin
            alu_w = alu_a;
            alu_c = 1'b0;
        end
        bus.I_DP_WRITE = alu_w;
        bus.I_DP_FLAGS = {alu_w[15], alu_w == 16'h0, alu_c, 2'b00};
    end

    always @(posedge clk or negedge bus.O_DP_NRESET) begin
        if (!bus.O_DP_NRESET) begin
            for (int i = 0; i < 16; i++) dp_regs[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) if (bus.O_DP_REG_EN[i]) dp_regs[i] <= alu_w;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] result, input logic overrun, input int latency);
        exp_q.push_back({latency[15:0], overrun, result});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (nrst && bus.O_DONE) begin
            logic [EW-1:0] e;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_result", {16'h0, bus.O_RESULT}, {16'h0, e[15:0]});
                check("done_overrun", {31'h0, bus.O_OVERRUN}, {31'h0, e[16]});
                check("done_latency", cyc - start_cyc, {16'h0, e[32:17]});
                check("done_busy", {31'h0, bus.O_BUSY}, 32'd1);
            end
            n_done++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_prog(input logic clr);
        @(negedge clk);
        bus.I_START      = 1'b1;
        bus.I_CLEAR_REGS = clr;
        start_cyc        = cyc + 1;
        @(negedge clk);
        bus.I_START      = 1'b0;
        bus.I_CLEAR_REGS = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int seen;
        bit ok;
        seen = n_done;
        ok   = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_done != seen) ok = 1'b1;
        end
        if (!ok) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_state_addr(input state_t s, input logic [7:0] addr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.O_DBG_STATE == s && bus.O_ROM_ADDR == addr) ok = 1'b1;
        end
        if (!ok) check("wait_state_timeout", 32'd1, 32'd0);
    endtask

    task automatic load_rom(input int sel);
        logic [31:0] fib [8];
        fib = '{32'h4107_0001, 32'h4117_0001, 32'h0120_0001, 32'h0131_0002,
                32'h0142_0003, 32'h0153_0004, 32'h0164_0005, 32'h8175_0006};
        for (int i = 0; i < 256; i++) rom[i] = (sel == 2) ? 32'h4100_0001 : 32'h0;
        if (sel == 0) begin
            for (int i = 0; i < 8; i++) rom[i] = fib[i];
        end else if (sel == 1) begin
            rom[0] = 32'h4107_0005;  // r0 = r7 + 5
            rom[1] = 32'h6130_8000;  // NO_WB: r0 + 0x8000, dest 3 not written
            rom[2] = 32'hD110_0001;  // LAST, reserved bit set: r1 = r0 + 1
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        cyc = 0; start_cyc = 0; n_done = 0; n_tests = 0; n_fail = 0;
        nrst = 1'b0;
        bus.I_START = 1'b0; bus.I_CLEAR_REGS = 1'b0; bus.I_HOLD = 1'b0;
        load_rom(0);
        repeat (3) @(negedge clk);

        check("rst_state", {29'h0, bus.O_DBG_STATE}, {29'h0, ST_IDLE});
        check("rst_busy", {31'h0, bus.O_BUSY}, 32'd0);
        check("rst_done", {30'h0, bus.O_DONE, bus.O_OVERRUN}, 32'd0);
        check("rst_result", {16'h0, bus.O_RESULT}, 32'd0);
        check("rst_flags", {27'h0, bus.O_FLAGS}, 32'd0);
        check("rst_reg_en", {16'h0, bus.O_DP_REG_EN}, 32'd0);
        check("rst_dp_nreset", {31'h0, bus.O_DP_NRESET}, 32'd0);
        check("rst_pc", {24'h0, bus.O_ROM_ADDR}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("idle_dp_nreset", {31'h0, bus.O_DP_NRESET}, 32'd1);

        // Fibonacci with clear: r7 = 21
        push_exp(16'h0015, 1'b0, 17);
        start_prog(1'b1);
        wait_done("fib_clear");
        @(negedge clk);
        check("fib_busy_after_done", {31'h0, bus.O_BUSY}, 32'd0);
        check("fib_done_pulse", {31'h0, bus.O_DONE}, 32'd0);

        // Same program without clear; r7 starts at 21, start pulse while busy is ignored
        push_exp(16'h01CE, 1'b0, 16);
        start_prog(1'b0);
        repeat (3) @(negedge clk);
        bus.I_START = 1'b1;
        @(negedge clk);
        bus.I_START = 1'b0;
        wait_done("fib_persist");

        // NO_WB op between writes
        load_rom(1);
        push_exp(16'h0006, 1'b0, 7);
        start_prog(1'b1);
        wait_state_addr(ST_EXEC, 8'h01, ok);
        if (ok) begin
            check("nowb_reg_en", {16'h0, bus.O_DP_REG_EN}, 32'd0);
            check("nowb_imm", {15'h0, bus.O_DP_IMM_SEL, bus.O_DP_IMM}, 32'h0001_8000);
            @(negedge clk);
            check("nowb_result_kept", {16'h0, bus.O_RESULT}, 32'h0005);
            check("nowb_flags", {27'h0, bus.O_FLAGS}, 32'h10);
        end
        wait_done("nowb");

        // Hold in FETCH of op 2 for 5 cycles
        load_rom(0);
        push_exp(16'h0015, 1'b0, 22);
        start_prog(1'b1);
        wait_state_addr(ST_FETCH, 8'h02, ok);
        if (ok) begin
            bus.I_HOLD = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("hold_addr", {24'h0, bus.O_ROM_ADDR}, 32'h02);
                check("hold_reg_en", {16'h0, bus.O_DP_REG_EN}, 32'd0);
            end
            bus.I_HOLD = 1'b0;
        end
        wait_done("hold");

        // 256 ops with no LAST: overrun, r0 incremented 256 times
        load_rom(2);
        push_exp(16'h0100, 1'b1, 513);
        start_prog(1'b1);
        wait_done("overrun");
        check("overrun_pc_done", {24'h0, bus.O_ROM_ADDR}, 32'hFF);
        @(negedge clk);
        check("overrun_pc_idle", {24'h0, bus.O_ROM_ADDR}, 32'hFF);
        check("overrun_pulse", {31'h0, bus.O_OVERRUN}, 32'd0);

        // Reset during EXEC of op 4
        load_rom(0);
        start_prog(1'b1);
        wait_state_addr(ST_EXEC, 8'h04, ok);
        if (ok) begin
            nrst = 1'b0;
            #1;
            check("abort_state", {29'h0, bus.O_DBG_STATE}, {29'h0, ST_IDLE});
            check("abort_reg_en", {16'h0, bus.O_DP_REG_EN}, 32'd0);
            check("abort_result", {16'h0, bus.O_RESULT}, 32'd0);
            check("abort_busy", {31'h0, bus.O_BUSY}, 32'd0);
            @(negedge clk);
            nrst = 1'b1;
            repeat (2) @(negedge clk);
            check("abort_stays_idle", {29'h0, bus.O_DBG_STATE}, {29'h0, ST_IDLE});
            check("abort_result_held", {16'h0, bus.O_RESULT}, 32'd0);
        end

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
